// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline stage: state encoding and occupancy values.
package pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // State values equal the occupancy so out_occ is the state register itself.
  typedef enum logic [1:0] {
    EMPTY = OCC_EMPTY,
    BUSY  = OCC_BUSY,
    FULL  = OCC_FULL
  } state_e;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready payload channel; master drives valid and data, slave drives ready.
interface pipe_skid_reg_if #(
  parameter int DATA_W = 32
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_skid_reg_core.sv
// Two-entry skid stage: main register feeds downstream, skid catches the beat accepted under stall.
module pipe_skid_reg_core
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cnt_clr,
  pipe_skid_reg_if.slave   up,
  pipe_skid_reg_if.master  dn,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              load_main, load_skid, main_from_skid;
  logic              up_xfer, dn_xfer, stall;

  assign up_xfer = up.valid & ready_q;
  assign dn_xfer = valid_q & dn.ready;
  assign stall   = valid_q & ~dn.ready;

  // ready/valid are registered copies of the next-state decode, so no path from dn.ready.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    // NOTE: defaults first keep this block free of inferred latches on paths that assign nothing.
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (up_xfer) begin
          state_d   = BUSY;
          load_main = 1'b1;
        end
        BUSY: begin
          if (up_xfer && dn_xfer) begin
            load_main = 1'b1;
          end else if (up_xfer) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (dn_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: if (dn_xfer) begin
          state_d        = BUSY;
          main_from_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    valid_d = (state_d != EMPTY);
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: payload registers are reset because the reset value of out_dn_data is observable.
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)           main_q <= up.data;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= up.data;
    end
  end

  assign up.ready = ready_q;
  assign dn.valid = valid_q;
  assign dn.data  = main_q;
  assign occ      = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Top wrapper: maps the flat port list onto two valid/ready channels around the skid core.
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              in_CLK,
  input  logic              in_RSTn,
  input  logic              in_FLUSH,
  input  logic              in_CNT_CLR,
  input  logic              in_up_valid,
  input  logic [DATA_W-1:0] in_up_data,
  output logic              out_up_ready,
  output logic              out_dn_valid,
  output logic [DATA_W-1:0] out_dn_data,
  input  logic              in_dn_ready,
  output logic [1:0]        out_occ,
  output logic [CNT_W-1:0]  out_stall_cnt
);

  pipe_skid_reg_if #(.DATA_W(DATA_W)) up_ch ();
  pipe_skid_reg_if #(.DATA_W(DATA_W)) dn_ch ();

  assign up_ch.valid  = in_up_valid;
  assign up_ch.data   = in_up_data;
  assign out_up_ready = up_ch.ready;

  assign out_dn_valid = dn_ch.valid;
  assign out_dn_data  = dn_ch.data;
  assign dn_ch.ready  = in_dn_ready;

  pipe_skid_reg_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_core (
    .clk       (in_CLK),
    .rst_n     (in_RSTn),
    .flush     (in_FLUSH),
    .cnt_clr   (in_CNT_CLR),
    .up        (up_ch.slave),
    .dn        (dn_ch.master),
    .occ       (out_occ),
    .stall_cnt (out_stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus random traffic against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic cnt_clr = 1'b0;
  logic [1:0]       occ;
  logic [CNT_W-1:0] stall_cnt;

  pipe_skid_reg_if #(.DATA_W(DATA_W)) up_if ();
  pipe_skid_reg_if #(.DATA_W(DATA_W)) dn_if ();

  pipe_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .in_CLK        (clk),
    .in_RSTn       (rst_n),
    .in_FLUSH      (flush),
    .in_CNT_CLR    (cnt_clr),
    .in_up_valid   (up_if.valid),
    .in_up_data    (up_if.data),
    .out_up_ready  (up_if.ready),
    .out_dn_valid  (dn_if.valid),
    .out_dn_data   (dn_if.data),
    .in_dn_ready   (dn_if.ready),
    .out_occ       (occ),
    .out_stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: held payloads in acceptance order, plus the stall count.
  logic [DATA_W-1:0] q[$];
  int m_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 64'(dn_if.valid), 64'(q.size() > 0));
    check({tag, "_ready"}, 64'(up_if.ready), 64'(q.size() < 2));
    check({tag, "_occ"},   64'(occ),         64'(q.size()));
    check({tag, "_cnt"},   64'(stall_cnt),   64'(m_cnt));
    if (q.size() > 0) check({tag, "_data"}, 64'(dn_if.data), 64'(q[0]));
  endtask

  // Advance one clock with the currently driven inputs, updating the model from pre-edge state.
  task automatic cycle(input string tag);
    int sz;
    bit up_fire, dn_fire, held;
    logic [DATA_W-1:0] head;
    sz      = q.size();
    dn_fire = (sz > 0) && dn_if.ready;
    up_fire = up_if.valid && (sz < 2);
    held    = (sz > 0) && !dn_if.ready && !flush;
    head    = (sz > 0) ? q[0] : '0;
    if (cnt_clr) m_cnt = 0;
    else if ((sz > 0) && !dn_if.ready && (m_cnt < CNT_MAX)) m_cnt++;
    if (flush) begin
      q.delete();
    end else begin
      if (dn_fire) void'(q.pop_front());
      if (up_fire) q.push_back(up_if.data);
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    if (held) check({tag, "_hold"}, 64'(dn_if.data), 64'(head));
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit r);
    up_if.valid = v;
    up_if.data  = d;
    dn_if.ready = r;
  endtask

  // Asynchronous reset mid-cycle: outputs must change before any clock edge.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_cnt = 0;
    check_outputs({tag, "_async"});
    check({tag, "_data0"}, 64'(dn_if.data), 64'd0);
    @(posedge clk);
    #1;
    check_outputs({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0);

    do_reset("rst0");

    // First beat into EMPTY shows up one cycle later.
    drive(1'b1, 32'hA5, 1'b1);
    cycle("a5");
    check("a5_lit_data", 64'(dn_if.data), 64'hA5);
    check("a5_lit_occ",  64'(occ), 64'd1);
    drive(1'b0, '0, 1'b1);
    cycle("a5_drain");

    // Fill both entries under stall, then drain in order.
    drive(1'b1, 32'h1, 1'b0);
    cycle("fill1");
    drive(1'b1, 32'h2, 1'b0);
    cycle("fill2");
    check("fill2_lit_occ",   64'(occ), 64'd2);
    check("fill2_lit_ready", 64'(up_if.ready), 64'd0);
    check("fill2_lit_data",  64'(dn_if.data), 64'h1);
    drive(1'b0, '0, 1'b1);
    cycle("drain1");
    check("drain1_lit_data", 64'(dn_if.data), 64'h2);
    cycle("drain2");
    check("drain2_lit_valid", 64'(dn_if.valid), 64'd0);

    // Flush from FULL, with a beat offered in the flush cycle.
    drive(1'b1, 32'h3, 1'b0);
    cycle("ffill1");
    drive(1'b1, 32'h4, 1'b0);
    cycle("ffill2");
    flush = 1'b1;
    drive(1'b1, 32'h5, 1'b1);
    cycle("flush");
    flush = 1'b0;
    check("flush_lit_valid", 64'(dn_if.valid), 64'd0);
    check("flush_lit_occ",   64'(occ), 64'd0);
    check("flush_lit_ready", 64'(up_if.ready), 64'd1);

    // Stall counter saturation and clear priority.
    drive(1'b0, '0, 1'b0);
    cnt_clr = 1'b1;
    cycle("cclr0");
    cnt_clr = 1'b0;
    drive(1'b1, 32'h6, 1'b0);
    cycle("cload");
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) cycle("cstall");
    check("csat_lit", 64'(stall_cnt), 64'd7);
    cnt_clr = 1'b1;
    cycle("cclr");
    cnt_clr = 1'b0;
    check("cclr_lit", 64'(stall_cnt), 64'd0);
    flush = 1'b1;
    cycle("cflush");
    flush = 1'b0;
    check("cflush_lit", 64'(stall_cnt), 64'd1);

    // Reset while FULL, then the next payload must be the first out.
    drive(1'b1, 32'h11, 1'b0);
    cycle("rfill1");
    drive(1'b1, 32'h22, 1'b0);
    cycle("rfill2");
    drive(1'b1, 32'h33, 1'b1);
    do_reset("rst_mid");
    drive(1'b1, 32'h77, 1'b1);
    cycle("post_rst");
    check("post_rst_lit", 64'(dn_if.data), 64'h77);
    drive(1'b0, '0, 1'b1);
    cycle("post_rst_drain");

    // Random traffic at 50% valid/ready, with occasional flush and counter clear.
    for (int i = 0; i < 10000; i++) begin
      flush   = ($urandom_range(0, 63) == 0);
      cnt_clr = ($urandom_range(0, 31) == 0);
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      cycle("rnd");
    end
    flush   = 1'b0;
    cnt_clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
